// File: rtl/des_pkg.sv
// Shared DES definitions for the encrypt and decrypt cores: permutation tables,
// S-boxes, key-schedule shift amounts, bit-permute and 28-bit rotate helpers.
// Table entries use DES numbering: bit 1 is the MSB of the source word.
package des_pkg;

    typedef logic [63:0] des_block_t;
    typedef logic [31:0] des_half_t;
    typedef logic [47:0] des_subkey_t;
    typedef logic [27:0] des_cd_t;

    // Every table is stored in a 64-entry array so one permute() serves them all;
    // entries past the table's real length are zero and are never read.
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

    localparam int E_T [64] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1,
        0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};

    localparam int P_T [64] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25,
        0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};

    localparam int PC1_T [64] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4,
        0, 0, 0, 0, 0, 0, 0, 0};

    localparam int PC2_T [64] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32,
        0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};

    // Each row holds 16 nibbles, column 0 in the top nibble.
    localparam logic [63:0] SBOX_T [8][4] = '{
        '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
        '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}};

    // Encrypt rotates left before each round; decrypt walks the same path backwards.
    localparam int LSHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int RSHIFT_T [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Result is right-aligned in n bits; src holds a src_w-bit value right-aligned.
    function automatic des_block_t permute(input des_block_t src, input int src_w,
                                           input int tbl [64], input int n);
        des_block_t res;
        res = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < n) res[n - 1 - i] = src[src_w - tbl[i]];
        end
        return res;
    endfunction

    function automatic des_cd_t rotl28(input des_cd_t x, input int n);
        return (x << n) | (x >> (28 - n));
    endfunction

    function automatic des_cd_t rotr28(input des_cd_t x, input int n);
        return (x >> n) | (x << (28 - n));
    endfunction

    function automatic logic [3:0] sbox(input int s, input logic [5:0] six);
        logic [63:0] row_w;
        row_w = SBOX_T[s][{six[5], six[0]}];
        return row_w[63 - 4 * six[4:1] -: 4];
    endfunction

endpackage

// File: rtl/des_f_function.sv
// DES round function f(R,K) = P(S(E(R) ^ K)); purely combinational, no handshake.
// Ports: r_in (32-bit right half), k_in (48-bit subkey), f_out (32-bit result).
module des_f_function
    import des_pkg::*;
(
    input  des_half_t   r_in,
    input  des_subkey_t k_in,
    output des_half_t   f_out
);

    des_subkey_t x;
    des_half_t   s_out;

    assign x = des_subkey_t'(permute({32'h0, r_in}, 32, E_T, 48)) ^ k_in;

    always_comb begin
        s_out = '0;
        for (int s = 0; s < 8; s++) begin
            s_out[31 - 4 * s -: 4] = sbox(s, x[47 - 6 * s -: 6]);
        end
    end

    assign f_out = des_half_t'(permute({32'h0, s_out}, 32, P_T, 32));

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative single-DES decrypt: IP, 16 rounds with subkeys K16..K1, FP.
// Latency: out_valid rises 16/ROUNDS_PER_CYCLE + 1 edges after accept; data held until out_ready.
// Ports: clk, reset (async, active-low), in_valid/in_ready + data_in/key, out_valid/out_ready + data_out, busy.
module des_decrypt_iter
    import des_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] data_in,
    input  logic [63:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] data_out,
    output logic        busy
);

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4) begin : g_bad_rpc
        $error("des_decrypt_iter: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0] state_q, state_d;
    des_half_t  l_q, l_d, r_q, r_d;
    des_cd_t    c_q, c_d, d_q, d_d;
    logic [4:0] cnt_q, cnt_d;
    des_block_t dout_q, dout_d;
    logic       ovld_q, ovld_d;

    des_block_t  ip_blk;
    logic [55:0] pc1_key;
    des_block_t  fp_blk;

    assign ip_blk  = permute(data_in, 64, IP_T, 64);
    assign pc1_key = 56'(permute(key, 64, PC1_T, 56));
    // The final round's swap is undone here: FP sees {R16, L16}.
    assign fp_blk  = permute({r_q, l_q}, 64, FP_T, 64);

    // Unrolled round chain; stage j performs round cnt_q + j + 1.
    des_half_t   l_s [ROUNDS_PER_CYCLE + 1];
    des_half_t   r_s [ROUNDS_PER_CYCLE + 1];
    des_cd_t     c_s [ROUNDS_PER_CYCLE + 1];
    des_cd_t     d_s [ROUNDS_PER_CYCLE + 1];
    des_subkey_t k_s [ROUNDS_PER_CYCLE];
    des_half_t   f_s [ROUNDS_PER_CYCLE];

    assign l_s[0] = l_q;
    assign r_s[0] = r_q;
    assign c_s[0] = c_q;
    assign d_s[0] = d_q;

    for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
        logic [3:0] ridx;
        // Wraps harmlessly when cnt_q is 16; the chain is unused in that cycle.
        assign ridx     = cnt_q[3:0] + 4'(j);
        // C/D after PC1 already equal C16/D16, so round 1 rotates by zero.
        assign c_s[j+1] = rotr28(c_s[j], RSHIFT_T[ridx]);
        assign d_s[j+1] = rotr28(d_s[j], RSHIFT_T[ridx]);
        assign k_s[j]   = des_subkey_t'(permute({8'h0, c_s[j+1], d_s[j+1]}, 56, PC2_T, 48));

        des_f_function u_f (
            .r_in  (r_s[j]),
            .k_in  (k_s[j]),
            .f_out (f_s[j])
        );

        assign l_s[j+1] = r_s[j];
        assign r_s[j+1] = l_s[j] ^ f_s[j];
    end

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        c_d     = c_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        ovld_d  = ovld_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    l_d     = ip_blk[63:32];
                    r_d     = ip_blk[31:0];
                    c_d     = pc1_key[55:28];
                    d_d     = pc1_key[27:0];
                    cnt_d   = 5'd0;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (cnt_q == 5'd16) begin
                    dout_d  = fp_blk;
                    ovld_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    l_d   = l_s[ROUNDS_PER_CYCLE];
                    r_d   = r_s[ROUNDS_PER_CYCLE];
                    c_d   = c_s[ROUNDS_PER_CYCLE];
                    d_d   = d_s[ROUNDS_PER_CYCLE];
                    cnt_d = cnt_q + 5'(ROUNDS_PER_CYCLE);
                end
            end
            ST_DONE: begin
                // No same-cycle accept: IDLE always lasts at least one cycle.
                if (out_ready) begin
                    ovld_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            ovld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            c_q     <= c_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            ovld_q  <= ovld_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = ovld_q;
    assign data_out  = dout_q;

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Bench for des_decrypt_iter: three instances (1, 2 and 4 rounds per cycle),
// known-answer vectors plus a reference DES model for random blocks.
module tb_des_decrypt_iter;
    import des_pkg::*;

    localparam logic [63:0] V1K = 64'h133457799BBCDFF1;
    localparam logic [63:0] V1C = 64'h85E813540F0AB405;
    localparam logic [63:0] V1P = 64'h0123456789ABCDEF;
    localparam logic [63:0] V2K = 64'h0E329232EA6D0D73;
    localparam logic [63:0] V2C = 64'h0000000000000000;
    localparam logic [63:0] V2P = 64'h8787878787878787;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  iv = '0;
    logic [2:0]  ird, ovl, bsy;
    logic [63:0] data_in = '0;
    logic [63:0] key = '0;
    logic        out_ready = 1'b1;
    logic [63:0] dout [3];

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    des_decrypt_iter #(.ROUNDS_PER_CYCLE(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ird[0]), .data_in(data_in),
        .key(key), .out_valid(ovl[0]), .out_ready(out_ready), .data_out(dout[0]), .busy(bsy[0]));
    des_decrypt_iter #(.ROUNDS_PER_CYCLE(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ird[1]), .data_in(data_in),
        .key(key), .out_valid(ovl[1]), .out_ready(out_ready), .data_out(dout[1]), .busy(bsy[1]));
    des_decrypt_iter #(.ROUNDS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ird[2]), .data_in(data_in),
        .key(key), .out_valid(ovl[2]), .out_ready(out_ready), .data_out(dout[2]), .busy(bsy[2]));

    // ---------------- reference model (forward key schedule, applied in reverse) ----------------
    function automatic logic [63:0] m_perm(input logic [63:0] src, input int w, input int tbl [64], input int n);
        logic [63:0] acc;
        acc = '0;
        for (int i = 0; i < n; i++) acc = {acc[62:0], src[w - tbl[i]]};
        return acc;
    endfunction

    function automatic logic [47:0] m_subkey(input logic [63:0] k, input int idx);
        logic [55:0] cd;
        logic [27:0] c, d;
        cd = 56'(m_perm(k, 64, PC1_T, 56));
        c = cd[55:28];
        d = cd[27:0];
        for (int j = 0; j <= idx; j++) begin
            for (int s = 0; s < LSHIFT_T[j]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
        end
        return 48'(m_perm({8'h0, c, d}, 56, PC2_T, 48));
    endfunction

    function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] so;
        logic [5:0]  six;
        logic [63:0] row_w;
        int          col;
        e  = 48'(m_perm({32'h0, r}, 32, E_T, 48)) ^ k;
        so = '0;
        for (int s = 0; s < 8; s++) begin
            six   = e[47 - 6 * s -: 6];
            row_w = SBOX_T[s][{six[5], six[0]}];
            col   = int'(six[4:1]);
            so    = {so[27:0], row_w[4 * (15 - col) +: 4]};
        end
        return 32'(m_perm({32'h0, so}, 32, P_T, 32));
    endfunction

    function automatic logic [63:0] m_decrypt(input logic [63:0] c, input logic [63:0] k);
        logic [63:0] x;
        logic [31:0] l, r, t;
        x = m_perm(c, 64, IP_T, 64);
        l = x[63:32];
        r = x[31:0];
        for (int i = 15; i >= 0; i--) begin
            t = r;
            r = l ^ m_f(r, m_subkey(k, i));
            l = t;
        end
        return m_perm({r, l}, 64, FP_T, 64);
    endfunction

    // ---------------- stimulus helper: offer one block, wait (bounded) for out_valid ----------------
    // Entered and left at #1 after a rising edge; returns observations, the caller compares.
    task automatic run_block(input int sel, input logic [63:0] c, input logic [63:0] k, input bit churn,
                             output int lat, output logic [63:0] dv, output bit busy_ok);
        data_in = c;
        key     = k;
        iv[sel] = 1'b1;
        @(posedge clk);
        #1;
        iv[sel] = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (!ovl[sel] && lat < 60) begin
            if (churn) begin
                data_in = {$urandom, $urandom};
                key     = {$urandom, $urandom};
            end
            @(negedge clk);
            if (!bsy[sel]) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        dv = dout[sel];
    endtask

    task automatic test_reset;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            n_vec++;
            if ({ird[s], ovl[s], bsy[s], dout[s]} !== {1'b1, 1'b0, 1'b0, 64'h0}) begin
                n_err++;
                $display("FAIL reset_state dut%0d: got rdy=%b vld=%b busy=%b dout=%h want 1 0 0 0",
                         s, ird[s], ovl[s], bsy[s], dout[s]);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        int lat; logic [63:0] dv, e; bit bok;
        exp_q.push_back(V1P);
        run_block(0, V1C, V1K, 1'b0, lat, dv, bok);
        e = exp_q.pop_front();
        n_vec++;
        if (lat != 17) begin n_err++; $display("FAIL basic_latency: got %0d want 17", lat); end
        n_vec++;
        if (dv !== e) begin n_err++; $display("FAIL basic_data: got %h want %h", dv, e); end
        n_vec++;
        if (!bok) begin n_err++; $display("FAIL basic_busy: busy dropped while in flight, want 1"); end
        @(posedge clk);
        #1;
        n_vec++;
        if ({ovl[0], ird[0]} !== 2'b01) begin
            n_err++; $display("FAIL basic_release: got vld=%b rdy=%b want 0 1", ovl[0], ird[0]);
        end
    endtask

    task automatic test_rpc_variants;
        int lat; logic [63:0] dv, e; bit bok;
        int want_lat [3] = '{17, 9, 5};
        for (int s = 0; s < 3; s++) begin
            exp_q.push_back(V2P);
            run_block(s, V2C, V2K, 1'b0, lat, dv, bok);
            e = exp_q.pop_front();
            n_vec++;
            if (lat != want_lat[s]) begin
                n_err++; $display("FAIL rpc_latency dut%0d: got %0d want %0d", s, lat, want_lat[s]);
            end
            n_vec++;
            if (dv !== e) begin n_err++; $display("FAIL rpc_data dut%0d: got %h want %h", s, dv, e); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure;
        int lat; logic [63:0] dv, e; bit bok;
        out_ready = 1'b0;
        exp_q.push_back(V1P);
        run_block(0, V1C, V1K, 1'b0, lat, dv, bok);
        e = exp_q.pop_front();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if ({ovl[0], ird[0], dout[0]} !== {1'b1, 1'b0, e}) begin
                n_err++;
                $display("FAIL bp_hold cyc%0d: got vld=%b rdy=%b dout=%h want 1 0 %h", i, ovl[0], ird[0], dout[0], e);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({ovl[0], ird[0]} !== 2'b01) begin
            n_err++; $display("FAIL bp_release: got vld=%b rdy=%b want 0 1", ovl[0], ird[0]);
        end
    endtask

    task automatic test_churn;
        int lat; logic [63:0] dv, e; bit bok;
        exp_q.push_back(V1P);
        run_block(0, V1C, V1K, 1'b1, lat, dv, bok);
        e = exp_q.pop_front();
        n_vec++;
        if (dv !== e) begin n_err++; $display("FAIL churn_rpc1: got %h want %h", dv, e); end
        @(posedge clk);
        #1;
        exp_q.push_back(V2P);
        run_block(2, V2C, V2K, 1'b1, lat, dv, bok);
        e = exp_q.pop_front();
        n_vec++;
        if (dv !== e) begin n_err++; $display("FAIL churn_rpc4: got %h want %h", dv, e); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid;
        int lat; logic [63:0] dv, e; bit bok, seen;
        exp_q.push_back(V1P);
        data_in = V1C;
        key     = V1K;
        iv[0]   = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        n_vec++;
        if ({ird[0], ovl[0], bsy[0], dout[0]} !== {1'b1, 1'b0, 1'b0, 64'h0}) begin
            n_err++;
            $display("FAIL midreset_state: got rdy=%b vld=%b busy=%b dout=%h want 1 0 0 0",
                     ird[0], ovl[0], bsy[0], dout[0]);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        seen  = 1'b0;
        repeat (30) begin @(negedge clk); if (ovl[0]) seen = 1'b1; end
        n_vec++;
        if (seen) begin n_err++; $display("FAIL midreset_no_output: got out_valid=1 want 0"); end
        @(posedge clk);
        #1;
        exp_q.push_back(V1P);
        run_block(0, V1C, V1K, 1'b0, lat, dv, bok);
        e = exp_q.pop_front();
        n_vec++;
        if (lat != 17 || dv !== e) begin
            n_err++; $display("FAIL midreset_fresh: got lat=%0d dout=%h want 17 %h", lat, dv, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        logic [63:0] sc [8];
        logic [63:0] sk [8];
        logic [63:0] e;
        int sent, got, cyc;
        bit seen;
        for (int i = 0; i < 8; i++) begin
            sc[i] = {$urandom, $urandom};
            sk[i] = {$urandom, $urandom};
        end
        sent = 0; got = 0; cyc = 0;
        data_in   = sc[0];
        key       = sk[0];
        iv[0]     = 1'b1;
        out_ready = 1'($urandom_range(1, 0));
        while (got < 8 && cyc < 3000) begin
            @(negedge clk);
            if (iv[0] && ird[0]) begin
                exp_q.push_back(m_decrypt(sc[sent], sk[sent]));
                sent++;
            end
            if (ovl[0] && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL stream_extra: got output %h with nothing outstanding", dout[0]);
                end else begin
                    e = exp_q.pop_front();
                    if (dout[0] !== e) begin
                        n_err++; $display("FAIL stream_data blk%0d: got %h want %h", got, dout[0], e);
                    end
                end
                got++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (sent < 8) begin
                data_in = sc[sent];
                key     = sk[sent];
            end else begin
                iv[0] = 1'b0;
            end
            out_ready = 1'($urandom_range(1, 0));
        end
        n_vec++;
        if (got != 8 || sent != 8) begin
            n_err++; $display("FAIL stream_count: got %0d outputs %0d accepts want 8 8", got, sent);
        end
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (30) begin @(negedge clk); if (ovl[0]) seen = 1'b1; end
        n_vec++;
        if (seen || exp_q.size() != 0) begin
            n_err++; $display("FAIL stream_tail: got extra_valid=%b pending=%0d want 0 0", seen, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rpc_variants();
        test_backpressure();
        test_churn();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
